mem_port_arbiter: RTL and testbench

- Shares the single external memory port between the instruction-cache refill path (instruction_fetch_data miss) and the data-cache fill/writeback path.
- Grants one requester at a time and holds the grant for a whole cache-line burst.
- Sequences command issue, beat counting and completion, and routes read beats back to the owner.
- Arbitration is round-robin, so fetch and data stalls cannot starve each other.

---
 rtl/mem_pkg.sv | 20 ++
 rtl/rr_arbiter2.sv | 22 ++
 rtl/mem_port_arbiter.sv | 146 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Types and constants shared by the external memory port arbiter and the cache blocks.
package mem_pkg;

  localparam int MEM_BURST_LEN  = 8;
  localparam int MEM_BEAT_BYTES = 4;
  localparam int MEM_LINE_BYTES = MEM_BURST_LEN * MEM_BEAT_BYTES;

  typedef enum logic {
    OWN_IC = 1'b0,
    OWN_DC = 1'b1
  } owner_e;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_CMD,
    ARB_RBURST,
    ARB_WBURST
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to whoever was not served last.
module rr_arbiter2
  import mem_pkg::*;
(
  input  logic [1:0] req,
  input  owner_e     rr_last,
  output logic       valid,
  output owner_e     winner
);

  always_comb begin
    // NOTE: every output gets a default first so no path through the block infers a latch.
    valid  = |req;
    winner = OWN_IC;
    if (req == 2'b11) begin
      winner = (rr_last == OWN_DC) ? OWN_IC : OWN_DC;
    end else if (req[1]) begin
      winner = OWN_DC;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one external memory port between icache refills and dcache fills/writebacks,
// holding the grant for a full line burst and routing read beats back to the owner.
module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int BURST_LEN = MEM_BURST_LEN
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic              ic_gnt,
  output logic              ic_rvalid,
  output logic [DATA_W-1:0] ic_rdata,
  output logic              ic_done,
  input  logic              dc_req,
  input  logic              dc_we,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [DATA_W-1:0] dc_wdata,
  output logic              dc_wready,
  output logic              dc_gnt,
  output logic              dc_rvalid,
  output logic [DATA_W-1:0] dc_rdata,
  output logic              dc_done,
  output logic              mem_cmd_valid,
  input  logic              mem_cmd_ready,
  output logic              mem_cmd_we,
  output logic [ADDR_W-1:0] mem_cmd_addr,
  output logic              mem_wvalid,
  input  logic              mem_wready,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(BURST_LEN);

  arb_state_e        state, state_nxt;
  owner_e            owner, rr_last, arb_winner;
  logic              arb_valid;
  logic [CNT_W-1:0]  beat_cnt;
  logic [ADDR_W-1:0] cmd_addr;
  logic              cmd_we;
  logic              rd_beat, wr_hs, last_beat, burst_end;

  rr_arbiter2 u_rr (
    .req     ({dc_req, ic_req}),
    .rr_last (rr_last),
    .valid   (arb_valid),
    .winner  (arb_winner)
  );

  assign rd_beat   = (state == ARB_RBURST) && mem_rvalid;
  assign wr_hs     = (state == ARB_WBURST) && mem_wready;
  assign last_beat = (beat_cnt == CNT_W'(BURST_LEN - 1));
  assign burst_end = (rd_beat || wr_hs) && last_beat;

  always_comb begin
    state_nxt     = state;
    ic_gnt        = 1'b0;
    ic_rvalid     = 1'b0;
    ic_rdata      = '0;
    ic_done       = 1'b0;
    dc_gnt        = 1'b0;
    dc_rvalid     = 1'b0;
    dc_rdata      = '0;
    dc_done       = 1'b0;
    dc_wready     = 1'b0;
    mem_cmd_valid = 1'b0;
    mem_cmd_we    = 1'b0;
    mem_cmd_addr  = '0;
    mem_wvalid    = 1'b0;
    mem_wdata     = '0;

    if (state != ARB_IDLE) begin
      ic_gnt = (owner == OWN_IC);
      dc_gnt = (owner == OWN_DC);
    end

    unique case (state)
      ARB_IDLE: begin
        if (arb_valid) state_nxt = ARB_CMD;
      end
      ARB_CMD: begin
        mem_cmd_valid = 1'b1;
        mem_cmd_we    = cmd_we;
        mem_cmd_addr  = cmd_addr;
        if (mem_cmd_ready) state_nxt = cmd_we ? ARB_WBURST : ARB_RBURST;
      end
      ARB_RBURST: begin
        if (owner == OWN_IC) begin
          ic_rvalid = mem_rvalid;
          ic_rdata  = mem_rvalid ? mem_rdata : '0;
          ic_done   = burst_end;
        end else begin
          dc_rvalid = mem_rvalid;
          dc_rdata  = mem_rvalid ? mem_rdata : '0;
          dc_done   = burst_end;
        end
        if (burst_end) state_nxt = ARB_IDLE;
      end
      ARB_WBURST: begin
        mem_wvalid = 1'b1;
        mem_wdata  = dc_wdata;
        dc_wready  = mem_wready;
        dc_done    = burst_end;
        if (burst_end) state_nxt = ARB_IDLE;
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  // Address and direction are captured at arbitration so the command stays stable through stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ARB_IDLE;
      owner    <= OWN_IC;
      rr_last  <= OWN_DC;
      beat_cnt <= '0;
      cmd_addr <= '0;
      cmd_we   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state <= state_nxt;
      if (state == ARB_IDLE && arb_valid) begin
        owner    <= arb_winner;
        cmd_addr <= (arb_winner == OWN_IC) ? ic_addr : dc_addr;
        cmd_we   <= (arb_winner == OWN_DC) && dc_we;
      end
      if (state == ARB_CMD && mem_cmd_ready) begin
        beat_cnt <= '0;
      end else if (rd_beat || wr_hs) begin
        beat_cnt <= beat_cnt + CNT_W'(1);
      end
      if (burst_end) rr_last <= owner;
    end
  end

  // Memory read beats can only legally arrive while a read burst is open.
  a_no_stray_rvalid : assert property (
    @(posedge clk) disable iff (!rst_n) mem_rvalid |-> (state == ARB_RBURST)
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter: refills, fills, writeback, fairness, stall, reset.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BL = 8;

  logic          clk, rst_n;
  logic          ic_req, ic_gnt, ic_rvalid, ic_done;
  logic [AW-1:0] ic_addr;
  logic [DW-1:0] ic_rdata;
  logic          dc_req, dc_we, dc_wready, dc_gnt, dc_rvalid, dc_done;
  logic [AW-1:0] dc_addr;
  logic [DW-1:0] dc_wdata, dc_rdata;
  logic          mem_cmd_valid, mem_cmd_ready, mem_cmd_we;
  logic [AW-1:0] mem_cmd_addr;
  logic          mem_wvalid, mem_wready, mem_rvalid;
  logic [DW-1:0] mem_wdata, mem_rdata;

  int checks   = 0;
  int failures = 0;
  int w;
  int hs;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BURST_LEN(BL)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ic_req        (ic_req),
    .ic_addr       (ic_addr),
    .ic_gnt        (ic_gnt),
    .ic_rvalid     (ic_rvalid),
    .ic_rdata      (ic_rdata),
    .ic_done       (ic_done),
    .dc_req        (dc_req),
    .dc_we         (dc_we),
    .dc_addr       (dc_addr),
    .dc_wdata      (dc_wdata),
    .dc_wready     (dc_wready),
    .dc_gnt        (dc_gnt),
    .dc_rvalid     (dc_rvalid),
    .dc_rdata      (dc_rdata),
    .dc_done       (dc_done),
    .mem_cmd_valid (mem_cmd_valid),
    .mem_cmd_ready (mem_cmd_ready),
    .mem_cmd_we    (mem_cmd_we),
    .mem_cmd_addr  (mem_cmd_addr),
    .mem_wvalid    (mem_wvalid),
    .mem_wready    (mem_wready),
    .mem_wdata     (mem_wdata),
    .mem_rvalid    (mem_rvalid),
    .mem_rdata     (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_idle_outs(input string tag);
    check({tag, "_ctl"}, 32'({ic_gnt, ic_rvalid, ic_done, dc_wready, dc_gnt, dc_rvalid,
                              dc_done, mem_cmd_valid, mem_cmd_we, mem_wvalid}), 32'h0);
    check({tag, "_dat"}, ic_rdata | dc_rdata | mem_wdata | mem_cmd_addr, 32'h0);
  endtask

  // Counts negedges until either grant is seen; a missing grant is a failed comparison.
  task automatic wait_gnt(output int waited);
    bit found;
    found  = 1'b0;
    waited = 0;
    for (int i = 0; i < 16 && !found; i++) begin
      @(negedge clk); #1;
      waited++;
      if (ic_gnt || dc_gnt) found = 1'b1;
    end
    if (!found) check("gnt_timeout", 32'd0, 32'd1);
  endtask

  // Entered in the CMD cycle with mem_cmd_ready already high; returns just after the done edge.
  task automatic read_burst(input string tag, input bit exp_ic, input logic [31:0] exp_addr,
                            input logic [31:0] base);
    check({tag, "_ic_gnt"}, 32'(ic_gnt), 32'(exp_ic));
    check({tag, "_dc_gnt"}, 32'(dc_gnt), 32'(!exp_ic));
    check({tag, "_cmd_valid"}, 32'(mem_cmd_valid), 32'd1);
    check({tag, "_cmd_addr"}, mem_cmd_addr, exp_addr);
    check({tag, "_cmd_we"}, 32'(mem_cmd_we), 32'd0);
    for (int i = 0; i < BL; i++) begin
      @(negedge clk);
      mem_rvalid = 1'b1;
      mem_rdata  = base + 32'(i);
      #1;
      check({tag, "_rvalid"}, 32'(exp_ic ? ic_rvalid : dc_rvalid), 32'd1);
      check({tag, "_rdata"}, exp_ic ? ic_rdata : dc_rdata, base + 32'(i));
      check({tag, "_other_rvalid"}, 32'(exp_ic ? dc_rvalid : ic_rvalid), 32'd0);
      check({tag, "_done"}, 32'(exp_ic ? ic_done : dc_done), 32'(i == BL - 1));
      check({tag, "_other_done"}, 32'(exp_ic ? dc_done : ic_done), 32'd0);
    end
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
  endtask

  initial begin
    rst_n = 1'b1;
    ic_req = 1'b0; ic_addr = '0;
    dc_req = 1'b0; dc_we = 1'b0; dc_addr = '0; dc_wdata = '0;
    mem_cmd_ready = 1'b0; mem_wready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    #3 rst_n = 1'b0;
    #1 check_idle_outs("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Single icache refill
    @(negedge clk);
    ic_req = 1'b1; ic_addr = 32'h1000; mem_cmd_ready = 1'b1;
    #1 check("t1_gnt_pre", 32'(ic_gnt), 32'd0);
    wait_gnt(w);
    check("t1_gnt_lat", w, 32'd1);
    read_burst("t1", 1'b1, 32'h1000, 32'hA0);
    ic_req = 1'b0;
    @(negedge clk); #1;
    check("t1_gnt_post", 32'(ic_gnt), 32'd0);

    // Simultaneous first request after reset: IC first, DC two cycles after ic_done
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    ic_req = 1'b1; ic_addr = 32'h1100;
    dc_req = 1'b1; dc_we = 1'b0; dc_addr = 32'h3000;
    wait_gnt(w);
    check("t2_ic_lat", w, 32'd1);
    read_burst("t2_ic", 1'b1, 32'h1100, 32'hB0);
    ic_req = 1'b0;
    wait_gnt(w);
    check("t2_dc_gap", w, 32'd2);
    read_burst("t2_dc", 1'b0, 32'h3000, 32'hC0);
    dc_req = 1'b0;

    // Round-robin fairness with both requests held for four bursts
    @(negedge clk);
    ic_req = 1'b1; ic_addr = 32'h1400;
    dc_req = 1'b1; dc_addr = 32'h3400;
    for (int k = 0; k < 4; k++) begin
      wait_gnt(w);
      check("t3_gap", w, (k == 0) ? 32'd1 : 32'd2);
      read_burst("t3", (k % 2) == 0, ((k % 2) == 0) ? 32'h1400 : 32'h3400, 32'h40 + 32'(16 * k));
    end
    ic_req = 1'b0; dc_req = 1'b0;

    // Writeback with a five-cycle command stall, then toggling write backpressure
    @(negedge clk);
    dc_req = 1'b1; dc_we = 1'b1; dc_addr = 32'h2040; mem_cmd_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 5) mem_cmd_ready = 1'b1;
      #1;
      check("t4_cmd_valid", 32'(mem_cmd_valid), 32'd1);
      check("t4_cmd_addr", mem_cmd_addr, 32'h2040);
      check("t4_cmd_we", 32'(mem_cmd_we), 32'd1);
      check("t4_cmd_wvalid", 32'(mem_wvalid), 32'd0);
    end
    hs = 0;
    for (int c = 0; c < 32 && hs < BL; c++) begin
      @(negedge clk);
      mem_wready = ((c % 2) == 0);
      dc_wdata   = 32'hD0 + 32'(hs);
      #1;
      check("t4_wvalid", 32'(mem_wvalid), 32'd1);
      check("t4_wready", 32'(dc_wready), 32'((c % 2) == 0));
      check("t4_wdata", mem_wdata, 32'hD0 + 32'(hs));
      check("t4_done", 32'(dc_done), 32'(((c % 2) == 0) && (hs == BL - 1)));
      check("t4_cmd_idle", 32'(mem_cmd_valid), 32'd0);
      if ((c % 2) == 0) hs++;
    end
    check("t4_handshakes", hs, 32'(BL));
    @(posedge clk); #1;
    mem_wready = 1'b0; dc_req = 1'b0; dc_we = 1'b0;
    @(negedge clk); #1;
    check("t4_gnt_post", 32'(dc_gnt), 32'd0);
    check("t4_wvalid_post", 32'(mem_wvalid), 32'd0);

    // Reset after beat 3 of a refill, then a clean dcache fill
    ic_req = 1'b1; ic_addr = 32'h1200;
    wait_gnt(w);
    check("t6_ic_gnt", 32'(ic_gnt), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mem_rvalid = 1'b1; mem_rdata = 32'hE0 + 32'(i);
      #1 check("t6_ic_rvalid", 32'(ic_rvalid), 32'd1);
    end
    @(negedge clk);
    mem_rvalid = 1'b0; mem_rdata = '0;
    rst_n = 1'b0;
    #1 check_idle_outs("t6_rst");
    ic_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dc_req = 1'b1; dc_we = 1'b0; dc_addr = 32'h3040;
    wait_gnt(w);
    check("t6_dc_lat", w, 32'd1);
    read_burst("t6_dc", 1'b0, 32'h3040, 32'hF0);
    dc_req = 1'b0;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
